// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit to data memory port
// Builds word-aligned requests, splits word-crossing accesses, extends load data.
module lsu_mem_ctrl #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_load,
    input  logic        i_req_store,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_dw,
    input  logic        i_req_sign,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t      r_state, w_next;
    logic        r_store, r_sign, r_err;
    logic [31:0] r_addr, r_wdata, r_lo, r_hi;
    logic [1:0]  r_dw;

    logic [7:0]  w_acc_be8, w_be8;
    logic        w_acc_err, w_cross, w_msb;
    logic [63:0] w_wd64;
    logic [31:0] w_r, w_mask, w_ldata, w_base_addr;

    function automatic logic [7:0] f_be8(input logic [1:0] dw, input logic [1:0] off);
        logic [7:0] base;
        case (dw)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] f_mask(input logic [1:0] dw);
        case (dw)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Legality is decided on the incoming fields so errors skip memory entirely
    assign w_acc_be8 = f_be8(i_req_dw, i_req_addr[1:0]);
    assign w_acc_err = (i_req_load == i_req_store) || (i_req_dw == 2'd3) ||
                       (!SPLIT_EN && (|w_acc_be8[7:4]));

    assign w_be8       = f_be8(r_dw, r_addr[1:0]);
    assign w_cross     = |w_be8[7:4];
    assign w_mask      = f_mask(r_dw);
    assign w_wd64      = {32'b0, r_wdata & w_mask} << {r_addr[1:0], 3'b000};
    assign w_base_addr = {r_addr[31:2], 2'b00};
    assign w_r         = 32'({r_hi, r_lo} >> {r_addr[1:0], 3'b000});

    always_comb begin
        case (r_dw)
            2'd0:    w_msb = w_r[7];
            2'd1:    w_msb = w_r[15];
            default: w_msb = w_r[31];
        endcase
    end

    assign w_ldata = (w_r & w_mask) | ((r_sign && w_msb) ? ~w_mask : 32'b0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_sign  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_dw    <= 2'b0;
            r_lo    <= 32'b0;
            r_hi    <= 32'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req_valid) begin
                r_store <= i_req_store;
                r_sign  <= i_req_sign;
                r_err   <= w_acc_err;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_dw    <= i_req_dw;
                r_lo    <= 32'b0;
                r_hi    <= 32'b0;
            end
            if (r_state == S_WAIT0 && i_mem_rvalid) r_lo <= i_mem_rdata;
            if (r_state == S_WAIT1 && i_mem_rvalid) r_hi <= i_mem_rdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_rdata = 32'b0;
        o_resp_err   = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = 32'b0;
        o_mem_be     = 4'b0;
        o_mem_wdata  = 32'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) w_next = w_acc_err ? S_RESP : S_REQ0;
            end
            S_REQ0: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_store;
                o_mem_addr  = w_base_addr;
                o_mem_be    = w_be8[3:0];
                o_mem_wdata = w_wd64[31:0];
                if (i_mem_gnt) w_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (i_mem_rvalid) w_next = w_cross ? S_REQ1 : S_RESP;
            end
            S_REQ1: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_store;
                o_mem_addr  = w_base_addr + 32'd4;
                o_mem_be    = w_be8[7:4];
                o_mem_wdata = w_wd64[63:32];
                if (i_mem_gnt) w_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (i_mem_rvalid) w_next = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
                o_resp_rdata = (r_err || r_store) ? 32'b0 : w_ldata;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl
// Drives both SPLIT_EN builds; only the selected instance receives req_valid.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v1, v0, ld, st, sgn, gnt, rv;
    logic [31:0] addr, wdata, mrdata;
    logic [1:0]  dw;
    bit          sel0;

    logic        rdy1, rsv1, err1, mreq1, mwe1;
    logic [31:0] rd1, ma1, mwd1;
    logic [3:0]  be1;
    logic        rdy0, rsv0, err0, mreq0, mwe0;
    logic [31:0] rd0, ma0, mwd0;
    logic [3:0]  be0;

    lsu_mem_ctrl #(.SPLIT_EN(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_load(ld), .i_req_store(st), .i_req_addr(addr), .i_req_wdata(wdata),
        .i_req_dw(dw), .i_req_sign(sgn), .o_resp_valid(rsv1), .o_resp_rdata(rd1),
        .o_resp_err(err1), .o_mem_req(mreq1), .o_mem_we(mwe1), .o_mem_addr(ma1),
        .o_mem_be(be1), .o_mem_wdata(mwd1), .i_mem_gnt(gnt), .i_mem_rvalid(rv),
        .i_mem_rdata(mrdata));

    lsu_mem_ctrl #(.SPLIT_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v0), .o_req_ready(rdy0),
        .i_req_load(ld), .i_req_store(st), .i_req_addr(addr), .i_req_wdata(wdata),
        .i_req_dw(dw), .i_req_sign(sgn), .o_resp_valid(rsv0), .o_resp_rdata(rd0),
        .o_resp_err(err0), .o_mem_req(mreq0), .o_mem_we(mwe0), .o_mem_addr(ma0),
        .o_mem_be(be0), .o_mem_wdata(mwd0), .i_mem_gnt(gnt), .i_mem_rvalid(rv),
        .i_mem_rdata(mrdata));

    logic        w_rdy, w_rsv, w_err, w_mreq, w_mwe;
    logic [31:0] w_rd, w_ma, w_mwd;
    logic [3:0]  w_be;
    assign w_rdy  = sel0 ? rdy0  : rdy1;
    assign w_rsv  = sel0 ? rsv0  : rsv1;
    assign w_err  = sel0 ? err0  : err1;
    assign w_mreq = sel0 ? mreq0 : mreq1;
    assign w_mwe  = sel0 ? mwe0  : mwe1;
    assign w_rd   = sel0 ? rd0   : rd1;
    assign w_ma   = sel0 ? ma0   : ma1;
    assign w_mwd  = sel0 ? mwd0  : mwd1;
    assign w_be   = sel0 ? be0   : be1;

    typedef struct { logic err; logic [31:0] rdata; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;
    resp_t resp_q[$];
    beat_t beat_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic e, input logic [31:0] rd);
        resp_t r;
        r.err = e; r.rdata = rd;
        resp_q.push_back(r);
    endtask

    // Plays the memory side cycle by cycle until the response arrives
    task automatic do_op(input bit d0, input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] w, input logic sg,
                         input int stall, input logic [31:0] lo, input logic [31:0] hi,
                         input int exp_lat);
        int    cyc, nbeat, st_left;
        bit    got, pend_rv, have_cap;
        logic [31:0] ca, cwd;
        logic [3:0]  cbe;
        resp_t er;
        beat_t eb;
        sel0 = d0; ld = l; st = s; addr = a; wdata = wd; dw = w; sgn = sg;
        #1 chk("ready_idle", 32'(w_rdy), 32'd1);
        if (d0) v0 = 1'b1; else v1 = 1'b1;
        @(negedge clk);
        v0 = 0; v1 = 0; ld = 0; st = 0; addr = 0; wdata = 0; dw = 0; sgn = 0;
        cyc = 1; nbeat = 0; st_left = stall; got = 0; pend_rv = 0; have_cap = 0;
        ca = 0; cwd = 0; cbe = 0;
        while (!got && cyc < 60) begin
            gnt = 0; rv = 0; mrdata = 0;
            if (w_rsv) begin
                got = 1;
                if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else begin
                    er = resp_q.pop_front();
                    chk("resp_err", 32'(w_err), 32'(er.err));
                    chk("resp_rdata", w_rd, er.rdata);
                end
                chk("latency", cyc, exp_lat);
            end else if (pend_rv) begin
                rv = 1; mrdata = (nbeat == 1) ? lo : hi; pend_rv = 0;
            end else if (w_mreq) begin
                chk("ready_busy", 32'(w_rdy), 32'd0);
                if (have_cap) begin
                    chk("stall_addr", w_ma, ca);
                    chk("stall_be", 32'(w_be), 32'(cbe));
                    chk("stall_wdata", w_mwd, cwd);
                end
                ca = w_ma; cbe = w_be; cwd = w_mwd; have_cap = 1;
                if (st_left > 0) st_left--;
                else begin
                    gnt = 1; nbeat++; pend_rv = 1; have_cap = 0;
                    if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
                    else begin
                        eb = beat_q.pop_front();
                        chk("mem_we", 32'(w_mwe), 32'(eb.we));
                        chk("mem_addr", w_ma, eb.addr);
                        chk("mem_be", 32'(w_be), 32'(eb.be));
                        chk("mem_wdata", w_mwd, eb.wdata);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        gnt = 0; rv = 0; mrdata = 0;
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        chk("resp_pulse", 32'(w_rsv), 32'd0);
        chk("ready_after", 32'(w_rdy), 32'd1);
        chk("beats_left", beat_q.size(), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(w_rdy), 32'd1);
        chk({tag, "_resp"}, {30'b0, w_rsv, w_err}, 32'd0);
        chk({tag, "_rdata"}, w_rd, 32'd0);
        chk({tag, "_mreq"}, {30'b0, w_mreq, w_mwe}, 32'd0);
        chk({tag, "_maddr"}, w_ma, 32'd0);
        chk({tag, "_mbe_wd"}, w_mwd | 32'(w_be), 32'd0);
    endtask

    initial begin
        rst_n = 0; v0 = 0; v1 = 0; ld = 0; st = 0; sgn = 0; gnt = 0; rv = 0;
        addr = 0; wdata = 0; mrdata = 0; dw = 0; sel0 = 0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1;
        @(negedge clk);

        push_beat(0, 32'h100, 4'b1000, 32'h0);
        push_resp(0, 32'hFFFF_FF80);
        do_op(0, 1, 0, 32'h103, 32'h0, 2'd0, 1, 0, 32'h8012_3456, 32'h0, 3);

        push_beat(1, 32'h100, 4'b1100, 32'h1234_0000);
        push_resp(0, 32'h0);
        do_op(0, 0, 1, 32'h102, 32'hABCD_1234, 2'd1, 0, 0, 32'h0, 32'h0, 3);

        push_beat(0, 32'h204, 4'b1100, 32'h0);
        push_beat(0, 32'h208, 4'b0011, 32'h0);
        push_resp(0, 32'h1234_5678);
        do_op(0, 1, 0, 32'h206, 32'h0, 2'd2, 0, 0, 32'h5678_ABCD, 32'hEEEE_1234, 5);

        push_resp(1, 32'h0);
        do_op(1, 1, 0, 32'h206, 32'h0, 2'd2, 0, 0, 32'h5678_ABCD, 32'hEEEE_1234, 1);

        push_resp(1, 32'h0);
        do_op(0, 1, 1, 32'h10, 32'h0, 2'd0, 0, 0, 32'h0, 32'h0, 1);
        push_resp(1, 32'h0);
        do_op(0, 1, 0, 32'h10, 32'h0, 2'd3, 0, 0, 32'h0, 32'h0, 1);
        push_resp(1, 32'h0);
        do_op(0, 0, 0, 32'h10, 32'h0, 2'd2, 0, 0, 32'h0, 32'h0, 1);

        push_beat(0, 32'h300, 4'b1111, 32'h0);
        push_resp(0, 32'hCAFE_F00D);
        do_op(0, 1, 0, 32'h300, 32'h0, 2'd2, 0, 5, 32'hCAFE_F00D, 32'h0, 8);

        push_beat(0, 32'hFFFF_FFFC, 4'b1000, 32'h0);
        push_beat(0, 32'h0000_0000, 4'b0001, 32'h0);
        push_resp(0, 32'hFFFF_CDAB);
        do_op(0, 1, 0, 32'hFFFF_FFFF, 32'h0, 2'd1, 1, 0, 32'hAB00_0000, 32'h0000_00CD, 5);

        push_beat(1, 32'h100, 4'b1110, 32'hADBE_EF00);
        push_beat(1, 32'h104, 4'b0001, 32'h0000_00DE);
        push_resp(0, 32'h0);
        do_op(0, 0, 1, 32'h101, 32'hDEAD_BEEF, 2'd2, 0, 0, 32'h0, 32'h0, 5);

        push_beat(0, 32'h200, 4'b0010, 32'h0);
        push_resp(0, 32'h0000_00A5);
        do_op(1, 1, 0, 32'h201, 32'h0, 2'd0, 0, 0, 32'h0000_A500, 32'h0, 3);

        push_beat(0, 32'h0, 4'b1100, 32'h0);
        push_resp(0, 32'h0000_8001);
        do_op(0, 1, 0, 32'h2, 32'h0, 2'd1, 0, 0, 32'h8001_1111, 32'h0, 3);

        sel0 = 0; ld = 1; st = 0; addr = 32'h400; dw = 2'd2; v1 = 1;
        @(negedge clk);
        v1 = 0; ld = 0; addr = 0; dw = 0;
        chk("rst_seq_req0", 32'(w_mreq), 32'd1);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        chk("rst_seq_wait0", {30'b0, w_mreq, w_rdy}, 32'd0);
        rst_n = 0;
        #1 chk_quiet("mid_reset");
        @(negedge clk);
        rst_n = 1; rv = 1; mrdata = 32'h1234_5678;
        @(negedge clk);
        rv = 0; mrdata = 0;
        for (int i = 0; i < 3; i++) begin
            chk_quiet("post_reset");
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
